// File: rtl/tge_pkg.sv
// Shared types and constants for the 10GbE transmit scheduler: FSM states,
// header field positions and the header builder.
package tge_pkg;

    localparam int         DEF_DATA_W    = 64;
    localparam logic [7:0] DEF_HDR_MAGIC = 8'hA5;

    localparam int HDR_MAGIC_LSB = 56;
    localparam int HDR_CH_LSB    = 48;
    localparam int HDR_LEN_LSB   = 32;
    localparam int HDR_SEQ_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_GAP
    } tx_state_t;

    function automatic logic [63:0] make_hdr(input logic [7:0]  magic,
                                             input logic [7:0]  ch,
                                             input logic [15:0] len,
                                             input logic [31:0] seq);
        logic [63:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8]  = magic;
        h[HDR_CH_LSB    +: 8]  = ch;
        h[HDR_LEN_LSB   +: 16] = len;
        h[HDR_SEQ_LSB   +: 32] = seq;
        return h;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority select: first requester strictly after last_grant,
// wrapping, with last_grant itself lowest priority.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int GW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0] req,
    input  logic [GW-1:0]   last_grant,
    output logic [GW-1:0]   grant,
    output logic            any_req
);

    logic [GW-1:0] idx;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant   = last_grant;
        any_req = |req;
        idx     = '0;
        // Walk from farthest to nearest so the nearest requester wins.
        for (int off = N_CH; off >= 1; off--) begin
            idx = GW'((int'(last_grant) + off) % N_CH);
            if (req[idx])
                grant = idx;
        end
    end

endmodule

// File: rtl/tge_tx_sched.sv
// Round-robin scheduler that drains full packets from per-channel FIFOs into
// one 10GbE TX port as header + payload frames with an enforced idle gap.
module tge_tx_sched
    import tge_pkg::*;
#(
    parameter int         N_CH       = 4,
    parameter int         DATA_W     = DEF_DATA_W,
    parameter int         PKT_WORDS  = 128,
    parameter int         CNT_W      = 10,
    parameter int         GAP_CYCLES = 4,
    parameter logic [7:0] HDR_MAGIC  = DEF_HDR_MAGIC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic [N_CH*CNT_W-1:0]    fifo_count,
    input  logic [N_CH-1:0]          fifo_empty,
    input  logic [N_CH*DATA_W-1:0]   fifo_dout,
    output logic [N_CH-1:0]          fifo_re,
    input  logic                     tx_afull,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_valid,
    output logic                     tx_eof,
    input  logic                     clr_err,
    output logic [N_CH-1:0]          underflow
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

    tx_state_t     state;
    logic [GW-1:0] gnt;
    logic [GW-1:0] last_grant;
    logic [15:0]   re_cnt;
    logic [15:0]   word_cnt;
    logic [15:0]   gap_cnt;
    logic [31:0]   seq [N_CH];

    logic [N_CH-1:0]   elig;
    logic [N_CH-1:0]   grant_oh;
    logic [GW-1:0]     arb_gnt;
    logic              arb_any;
    logic [DATA_W-1:0] hdr_word;
    logic [DATA_W-1:0] pay_word;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CH; i++)
            elig[i] = ch_mask[i] &&
                      (32'(fifo_count[i*CNT_W +: CNT_W]) >= 32'(PKT_WORDS));
    end

    rr_arbiter #(.N_CH(N_CH), .GW(GW)) u_arb (
        .req        (elig),
        .last_grant (last_grant),
        .grant      (arb_gnt),
        .any_req    (arb_any)
    );

    always_comb begin
        grant_oh          = '0;
        grant_oh[arb_gnt] = 1'b1;
        hdr_word = DATA_W'(make_hdr(HDR_MAGIC, 8'(gnt), 16'(PKT_WORDS), seq[gnt]));
        pay_word = fifo_dout[gnt*DATA_W +: DATA_W];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            last_grant <= GW'(N_CH - 1);
            fifo_re    <= '0;
            re_cnt     <= '0;
            word_cnt   <= '0;
            gap_cnt    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tx_eof     <= 1'b0;
            underflow  <= '0;
            // NOTE: seq is a tiny register array, not RAM, so it can and must be reset explicitly.
            for (int i = 0; i < N_CH; i++)
                seq[i] <= '0;
        end else begin
            // A fresh underflow beats a simultaneous clear.
            underflow <= (underflow & ~{N_CH{clr_err}}) | (fifo_re & fifo_empty);

            // The read strobe runs independently of the output pipeline: it
            // stops itself after exactly PKT_WORDS reads.
            if (fifo_re != '0) begin
                re_cnt <= re_cnt + 16'd1;
                if (re_cnt == 16'(PKT_WORDS - 1))
                    fifo_re <= '0;
            end

            case (state)
                ST_IDLE: begin
                    tx_valid <= 1'b0;
                    tx_eof   <= 1'b0;
                    if (en && !tx_afull && arb_any) begin
                        gnt        <= arb_gnt;
                        last_grant <= arb_gnt;
                        fifo_re    <= grant_oh;
                        re_cnt     <= '0;
                        state      <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    tx_data   <= hdr_word;
                    tx_valid  <= 1'b1;
                    tx_eof    <= 1'b0;
                    seq[gnt]  <= seq[gnt] + 32'd1;
                    word_cnt  <= '0;
                    state     <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    tx_data  <= pay_word;
                    tx_valid <= 1'b1;
                    tx_eof   <= (word_cnt == 16'(PKT_WORDS - 1));
                    word_cnt <= word_cnt + 16'd1;
                    if (word_cnt == 16'(PKT_WORDS - 1)) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    tx_valid <= 1'b0;
                    tx_eof   <= 1'b0;
                    gap_cnt  <= gap_cnt + 16'd1;
                    if (gap_cnt == 16'(GAP_CYCLES - 1))
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tge_tx_sched.sv
// Scoreboard bench for tge_tx_sched: stimulus pushes expected frame words,
// a negedge monitor pops and compares every valid TX word.
module tb_tge_tx_sched;

    localparam int N_CH = 4;
    localparam int DW   = 64;
    localparam int P    = 128;
    localparam int CW   = 10;
    localparam int GAP  = 4;

    typedef struct packed {
        logic [63:0] data;
        logic        eof;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [N_CH-1:0]      ch_mask;
    logic [N_CH*CW-1:0]   fifo_count;
    logic [N_CH-1:0]      fifo_empty;
    logic [N_CH*DW-1:0]   fifo_dout;
    logic [N_CH-1:0]      fifo_re;
    logic                 tx_afull;
    logic [DW-1:0]        tx_data;
    logic                 tx_valid;
    logic                 tx_eof;
    logic                 clr_err;
    logic [N_CH-1:0]      underflow;

    tge_tx_sched #(
        .N_CH(N_CH), .DATA_W(DW), .PKT_WORDS(P), .CNT_W(CW),
        .GAP_CYCLES(GAP), .HDR_MAGIC(8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ch_mask    (ch_mask),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_re    (fifo_re),
        .tx_afull   (tx_afull),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_eof     (tx_eof),
        .clr_err    (clr_err),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pat(input int ch, input int idx);
        return {16'hC0DE, 8'(ch), 8'h00, 32'(idx)};
    endfunction

    function automatic logic [63:0] hdr(input int ch, input int seq);
        return {8'hA5, 8'(ch), 16'(P), 32'(seq)};
    endfunction

    // FIFO model: read data appears one cycle after the read enable.
    int   rd_idx[N_CH];
    logic rd_clr;
    always @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rd_clr)
                rd_idx[i] <= 0;
            else if (fifo_re[i]) begin
                fifo_dout[i*DW +: DW] <= pat(i, rd_idx[i]);
                rd_idx[i]             <= rd_idx[i] + 1;
            end
        end
    end

    // Monitor
    int   hdr_seen = 0, eof_seen = 0, mon_words = 0, gap_run = 0, valid_cycles = 0;
    bit   in_frame = 0, after_eof = 0, measure_gap = 0;
    exp_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 0;
            after_eof = 0;
            mon_words = 0;
            gap_run   = 0;
        end else begin
            if (in_frame)
                check("no_bubble", 64'(tx_valid), 64'(1));
            if (tx_valid) begin
                valid_cycles++;
                if (!in_frame) begin
                    hdr_seen++;
                    in_frame  = 1;
                    mon_words = 0;
                    if (measure_gap && after_eof)
                        check("gap_len", 64'(gap_run), 64'(GAP + 1));
                end
                mon_words++;
                check("sb_nonempty", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("tx_data", tx_data, e.data);
                    check("tx_eof", 64'(tx_eof), 64'(e.eof));
                end
                if (tx_eof) begin
                    eof_seen++;
                    check("frame_len", 64'(mon_words), 64'(P + 1));
                    in_frame  = 0;
                    after_eof = 1;
                    gap_run   = 0;
                end
            end else begin
                gap_run++;
            end
        end
    end

    int exp_ptr[N_CH];

    task automatic push_frame(input int ch, input logic [63:0] h);
        sb.push_back('{data: h, eof: 1'b0});
        for (int k = 0; k < P; k++)
            sb.push_back('{data: pat(ch, exp_ptr[ch] + k), eof: (k == P - 1)});
        exp_ptr[ch] += P;
    endtask

    task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
        fifo_count = {10'(c3), 10'(c2), 10'(c1), 10'(c0)};
    endtask

    task automatic wait_hdr(input int target);
        int t = 0;
        while (hdr_seen < target && t < 3000) begin @(negedge clk); #1; t++; end
        check("wait_hdr", 64'(hdr_seen >= target), 64'(1));
    endtask

    task automatic wait_eof(input int target);
        int t = 0;
        while (eof_seen < target && t < 3000) begin @(negedge clk); #1; t++; end
        check("wait_eof", 64'(eof_seen >= target), 64'(1));
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        rd_clr = 1'b1;
        sb.delete();
        for (int i = 0; i < N_CH; i++) exp_ptr[i] = 0;
        repeat (3) @(negedge clk);
        #1;
        rd_clr = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        int  h0, e0, base, t, v0;
        bit  hit;
        en = 0; ch_mask = '1; fifo_empty = '0; tx_afull = 0; clr_err = 0;
        set_counts(0, 0, 0, 0);
        rst_n = 0; rd_clr = 1;
        for (int i = 0; i < N_CH; i++) exp_ptr[i] = 0;
        repeat (2) @(negedge clk);
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_tx_eof", 64'(tx_eof), 64'(0));
        check("rst_tx_data", tx_data, 64'(0));
        check("rst_fifo_re", 64'(fifo_re), 64'(0));
        check("rst_underflow", 64'(underflow), 64'(0));
        do_reset();

        // Single channel
        push_frame(1, 64'hA501_0080_0000_0000);
        set_counts(0, 128, 0, 0);
        en = 1;
        wait_hdr(1);
        set_counts(0, 0, 0, 0);
        wait_eof(1);
        repeat (10) @(negedge clk);

        // All four channels continuously full
        en = 0;
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < N_CH; c++)
                push_frame(c, hdr(c, r));
        e0 = eof_seen;
        measure_gap = 1;
        set_counts(128, 128, 128, 128);
        en = 1;
        wait_eof(e0 + 12);
        en = 0;
        measure_gap = 0;
        set_counts(0, 0, 0, 0);
        repeat (10) @(negedge clk);
        check("t2_underflow", 64'(underflow), 64'(0));

        // Mask 1010, then cleared mid-frame
        push_frame(1, hdr(1, 3));
        push_frame(3, hdr(3, 3));
        push_frame(1, hdr(1, 4));
        h0 = hdr_seen; e0 = eof_seen;
        ch_mask = 4'b1010;
        set_counts(128, 128, 128, 128);
        en = 1;
        wait_hdr(h0 + 3);
        ch_mask = 4'b0000;
        wait_eof(e0 + 3);
        repeat (20) @(negedge clk);
        set_counts(0, 0, 0, 0);
        ch_mask = 4'b1111;

        // tx_afull holds off a full ch0, release gives header 2 cycles later
        tx_afull = 1;
        set_counts(128, 0, 0, 0);
        v0 = valid_cycles;
        repeat (20) @(negedge clk);
        #1;
        check("afull_no_frame", 64'(valid_cycles - v0), 64'(0));
        check("afull_no_read", 64'(fifo_re), 64'(0));
        push_frame(0, hdr(0, 3));
        h0 = hdr_seen; e0 = eof_seen;
        tx_afull = 0;
        @(posedge clk);
        @(negedge clk); #1;
        check("lat_cyc1_re", 64'(fifo_re), 64'(4'b0001));
        check("lat_cyc1_valid", 64'(tx_valid), 64'(0));
        @(negedge clk); #1;
        check("lat_cyc2_valid", 64'(tx_valid), 64'(1));
        wait_hdr(h0 + 1);
        set_counts(0, 0, 0, 0);
        wait_eof(e0 + 1);

        // Underflow on read 50 of a ch2 frame
        base = exp_ptr[2];
        push_frame(2, hdr(2, 3));
        e0 = eof_seen;
        set_counts(0, 0, 128, 0);
        hit = 0; t = 0;
        while (!hit && t < 400) begin
            @(negedge clk); #1; t++;
            if (rd_idx[2] == base + 49) hit = 1;
        end
        check("ufl_trigger", 64'(hit), 64'(1));
        fifo_empty = 4'b0100;
        set_counts(0, 0, 0, 0);
        @(negedge clk); #1;
        fifo_empty = '0;
        wait_eof(e0 + 1);
        check("underflow_set", 64'(underflow), 64'(4'b0100));
        clr_err = 1;
        @(negedge clk); #1;
        clr_err = 0;
        check("underflow_clr", 64'(underflow), 64'(0));

        // Reset during payload word 60
        push_frame(3, hdr(3, 4));
        set_counts(128, 0, 0, 128);
        hit = 0; t = 0;
        while (!hit && t < 400) begin
            @(negedge clk); #1; t++;
            if (in_frame && mon_words == 61) hit = 1;
        end
        check("rst_trigger", 64'(hit), 64'(1));
        rst_n  = 0;
        rd_clr = 1;
        #1;
        check("midrst_tx_valid", 64'(tx_valid), 64'(0));
        check("midrst_tx_eof", 64'(tx_eof), 64'(0));
        check("midrst_fifo_re", 64'(fifo_re), 64'(0));
        sb.delete();
        for (int i = 0; i < N_CH; i++) exp_ptr[i] = 0;
        push_frame(0, hdr(0, 0));
        repeat (2) @(negedge clk);
        #1;
        rd_clr = 0;
        h0 = hdr_seen; e0 = eof_seen;
        rst_n = 1;
        wait_hdr(h0 + 1);
        set_counts(0, 0, 0, 0);
        wait_eof(e0 + 1);
        repeat (10) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
